// File: rtl/commu_push_if.sv
// Bundle between commu_push and its neighbours: sequencer handshake,
// slot-buffer read port and the byte transmit channel.
interface commu_push_if;
    logic        fire_push;
    logic        done_push;
    logic        buf_rd;
    logic [7:0]  buf_addr;
    logic [15:0] buf_q;
    logic [7:0]  tx_dat;
    logic        tx_vld;
    logic        tx_rdy;
    logic [7:0]  push_sum;

    modport master (
        input  fire_push, buf_q, tx_rdy,
        output done_push, buf_rd, buf_addr, tx_dat, tx_vld, push_sum
    );

    modport slave (
        output fire_push, buf_q, tx_rdy,
        input  done_push, buf_rd, buf_addr, tx_dat, tx_vld, push_sum
    );
endinterface

// File: rtl/commu_push.sv
// Payload-push stage: reads DATA_LEN words from the slot buffer and sends
// them high byte first on the transmit channel, keeping a mod-256 byte sum.
module commu_push #(
    parameter int unsigned DATA_LEN  = 64,
    parameter logic [7:0]  BASE_ADDR = 8'h00
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    commu_push_if.master  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_TX_H  = 3'd3;
    localparam logic [2:0] S_TX_L  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Nine bits so that DATA_LEN = 256 still reaches its last index.
    localparam logic [8:0] LAST_IDX = 9'(DATA_LEN - 1);

    logic [2:0]  state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] word_q, word_d;

    function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (bus.fire_push) begin
                    state_d = S_RD;
                    cnt_d   = '0;
                    addr_d  = BASE_ADDR;
                    sum_d   = '0;
                end
            end
            S_RD: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                word_d  = bus.buf_q;
                state_d = S_TX_H;
            end
            S_TX_H: begin
                if (bus.tx_rdy) begin
                    sum_d   = sum_add(sum_q, word_q[15:8]);
                    state_d = S_TX_L;
                end
            end
            S_TX_L: begin
                if (bus.tx_rdy) begin
                    sum_d = sum_add(sum_q, word_q[7:0]);
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 9'd1;
                        addr_d  = addr_q + 8'd1;
                        state_d = S_RD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        word_q <= word_d;
    end

    // Outputs come only from flops; tx_dat is zero whenever tx_vld is low.
    assign bus.buf_rd    = (state_q == S_RD);
    assign bus.tx_vld    = (state_q == S_TX_H) || (state_q == S_TX_L);
    assign bus.done_push = (state_q == S_DONE);
    assign bus.buf_addr  = addr_q;
    assign bus.push_sum  = sum_q;
    assign bus.tx_dat    = (state_q == S_TX_H) ? word_q[15:8] :
                           (state_q == S_TX_L) ? word_q[7:0]  : 8'h00;
endmodule

// File: doc/commu_push.md
# commu_push

Payload-push stage of the communication transmitter, driven by the main sequencer's `fire_push` / `done_push` handshake. On each fire it reads a fixed-length block of 16-bit words from the slot buffer and serialises them, high byte first, onto the byte transmit interface with valid/ready flow control. It also keeps a modulo-256 byte checksum, which the tail stage appends. It sits between the main sequencer and the byte transmitter, in parallel with the head and tail stages.

## Interface
Parameters:
- DATA_LEN, 64: words per push. Legal range 1..256.
- BASE_ADDR, 8'h00: first buffer word address. Addresses increment modulo 256.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fire_push  in  1  start pulse from the main sequencer.
- done_push  out  1  one-cycle completion pulse to the main sequencer.
- buf_rd  out  1  buffer read strobe.
- buf_addr  out  8  buffer word address.
- buf_q  in  16  buffer read data, valid on the cycle after `buf_rd`.
- tx_dat  out  8  transmit byte.
- tx_vld  out  1  `tx_dat` is valid.
- tx_rdy  in  1  transmitter accepts the byte.
- push_sum  out  8  modulo-256 sum of all bytes sent in the last push.

## Operation
- FSM states: S_IDLE, S_RD, S_LATCH, S_TX_H, S_TX_L, S_DONE.
- S_IDLE -> S_RD when `fire_push` = 1.
  - On this transition: word counter <= 0, `buf_addr` <= BASE_ADDR, `push_sum` <= 0.
- S_RD: `buf_rd` = 1 for exactly one cycle. Always -> S_LATCH.
- S_LATCH: capture `buf_q` into the word register. Always -> S_TX_H.
- S_TX_H: `tx_vld` = 1, `tx_dat` = word[15:8].
  - If `tx_rdy` = 1: `push_sum` += byte, -> S_TX_L. Otherwise stay.
- S_TX_L: `tx_vld` = 1, `tx_dat` = word[7:0].
  - If `tx_rdy` = 1: `push_sum` += byte.
    - If counter == DATA_LEN-1: -> S_DONE.
    - Otherwise: counter += 1, `buf_addr` += 1 (8-bit wrap), -> S_RD.
  - If `tx_rdy` = 0: stay.
- S_DONE: `done_push` = 1. Always -> S_IDLE.
- Any undefined state code -> S_IDLE.
- Arithmetic:
  - `push_sum` is an 8-bit wrapping add.
  - The counter is 9 bits wide, so DATA_LEN = 256 terminates correctly.
- `fire_push` in any state other than S_IDLE is ignored; it is not queued.
- `push_sum` holds its value from S_DONE until the next accepted fire.
- A byte transfer happens only on a cycle where `tx_vld` & `tx_rdy` are both 1. While `tx_vld` = 1 and `tx_rdy` = 0, `tx_dat` stays stable.
- `tx_vld` is 0 in S_IDLE, S_RD, S_LATCH and S_DONE.
- `tx_rdy` asserted while `tx_vld` = 0 has no effect.

## Timing
- Reset values: state S_IDLE; `done_push`, `buf_rd`, `tx_vld` = 0; `tx_dat`, `buf_addr`, `push_sum` = 0; counter = 0.
- Reset mid-operation takes effect immediately and asynchronously. The next fire restarts from BASE_ADDR with the sum cleared.
- All outputs are registered or decoded from the state register only. There is no combinational path from `tx_rdy` or `fire_push` to any output.
- Cycle numbering: `fire_push` is sampled at edge k.
  - Word i, with `tx_rdy` held at 1:
    - S_RD in cycle k+1+4i
    - S_LATCH in cycle k+2+4i
    - S_TX_H in cycle k+3+4i
    - S_TX_L in cycle k+4+4i
  - `done_push` is high in cycle k+4·DATA_LEN+1.
- Each cycle with `tx_rdy` = 0 while `tx_vld` = 1 adds exactly one cycle to this latency.
- Earliest re-fire: `fire_push` is accepted in the cycle after `done_push`.

## Test plan
- Nominal run:
  - Stimulus: DATA_LEN=4, BASE_ADDR=0. Buffer holds 0x1234, 0x5678, 0x9ABC, 0xDEF0. `tx_rdy` held at 1.
  - Required: `tx_dat` sequence 12 34 56 78 9A BC DE F0. `buf_addr` 0,1,2,3. `done_push` in cycle k+17. `push_sum` = 0x38.
- Backpressure:
  - Stimulus: same as nominal, with `tx_rdy` = 0 for cycles k+3..k+5.
  - Required: `tx_dat` = 0x12 held stable with `tx_vld` = 1 throughout. `done_push` in cycle k+20. Identical byte sequence. `push_sum` = 0x38.
- Fire while busy:
  - Stimulus: `fire_push` pulsed again at k+6.
  - Required: ignored. Exactly 8 bytes sent and a single `done_push`. A fire in cycle k+18 starts a new run with `push_sum` reset to 0.
- Address wrap:
  - Stimulus: BASE_ADDR=0xFE, DATA_LEN=4.
  - Required: `buf_addr` sequence FE, FF, 00, 01, with one `buf_rd` per address.
- Reset mid-transfer:
  - Stimulus: `rst_n` low at k+9.
  - Required: all outputs 0 immediately, state S_IDLE. A subsequent fire reads from BASE_ADDR again, the first byte is 0x12, and the completed run gives `push_sum` = 0x38.
- Single word:
  - Stimulus: DATA_LEN=1, buffer word 0xFF02.
  - Required: bytes FF 02. `done_push` in cycle k+5. `push_sum` = 0x01.
